// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver + scan-code decoder (make/break, E0 extended); `KEY_REPEAT_FILTER_EN drops typematic repeats.
// Latency: ready two clk cycles after the cycle the synchronised stop bit is sampled.
// Backpressure: none; the keyboard cannot be stalled, so the downstream stage must take every ready strobe.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [2:0] key_val,
  output logic       press,
  output logic       ready,
  output logic       frame_err
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  // Synchronisers reset high so an idle bus produces no spurious edge.
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  logic ps2_fall;
  logic ps2_bit;
  assign ps2_fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign ps2_bit  = dat_sync[SYNC_STAGES-1];

  rx_state_t       rx_state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_dat;
  logic            par_bit;
  logic [TW-1:0]   to_cnt;
  logic            byte_vld;
  logic [7:0]      byte_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state  <= IDLE;
      bit_cnt   <= 3'd0;
      shift_dat <= 8'h00;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
      byte_vld  <= 1'b0;
      byte_dat  <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      if (ps2_fall) begin
        to_cnt <= '0;
        case (rx_state)
          IDLE: begin
            if (!ps2_bit) begin
              rx_state <= DATA;
              bit_cnt  <= 3'd0;
            end
          end
          DATA: begin
            shift_dat <= {ps2_bit, shift_dat[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) rx_state <= PARITY;
          end
          PARITY: begin
            par_bit  <= ps2_bit;
            rx_state <= STOP;
          end
          default: begin
            if (ps2_bit && (^{shift_dat, par_bit})) begin
              byte_vld <= 1'b1;
              byte_dat <= shift_dat;
            end else begin
              frame_err <= 1'b1;
            end
            rx_state <= IDLE;
          end
        endcase
      end else if (rx_state == IDLE) begin
        to_cnt <= '0;
      end else if (to_cnt == TO_MAX) begin
        to_cnt    <= '0;
        rx_state  <= IDLE;
        frame_err <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // {hit, code}; a code only matches under its own ext value.
  function automatic logic [3:0] lookup(input logic e, input logic [7:0] b);
    case ({e, b})
      9'h016:  lookup = 4'b1_000;
      9'h01E:  lookup = 4'b1_001;
      9'h026:  lookup = 4'b1_010;
      9'h025:  lookup = 4'b1_011;
      9'h175:  lookup = 4'b1_100;
      9'h172:  lookup = 4'b1_101;
      9'h16B:  lookup = 4'b1_110;
      9'h174:  lookup = 4'b1_111;
      default: lookup = 4'b0_000;
    endcase
  endfunction

  logic       ext;
  logic       brk;
  logic [3:0] lk;
  assign lk = lookup(ext, byte_dat);

`ifdef KEY_REPEAT_FILTER_EN
  logic [7:0] held;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext     <= 1'b0;
      brk     <= 1'b0;
      key_val <= 3'b000;
      press   <= 1'b1;
      ready   <= 1'b0;
`ifdef KEY_REPEAT_FILTER_EN
      held    <= 8'h00;
`endif
    end else begin
      ready <= 1'b0;
      if (frame_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_vld) begin
        if (byte_dat == 8'hE0) begin
          ext <= 1'b1;
        end else if (byte_dat == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (lk[3]) begin
`ifdef KEY_REPEAT_FILTER_EN
            if (brk) begin
              held[lk[2:0]] <= 1'b0;
              key_val <= lk[2:0];
              press   <= 1'b0;
              ready   <= 1'b1;
            end else if (!held[lk[2:0]]) begin
              held[lk[2:0]] <= 1'b1;
              key_val <= lk[2:0];
              press   <= 1'b1;
              ready   <= 1'b1;
            end
`else
            key_val <= lk[2:0];
            press   <= ~brk;
            ready   <= 1'b1;
`endif
          end
        end
      end
    end
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Receives PS/2 keyboard serial frames and translates scan codes into the 3-bit key code, press flag and ready strobe consumed by the car controller stage directly downstream.
- Recognises make and break (F0) codes and the extended (E0) prefix.
- Maps eight keys: number keys 1-4 select speed; the arrow keys select direction and steering.
- All other keys are silently dropped.

Parameters:
- TIMEOUT_CYCLES, 100000: clk cycles without a ps2_clk falling edge mid-frame before the frame is aborted (about 1 ms at 100 MHz).
- SYNC_STAGES, 2: flip-flop depth of the input synchronisers on ps2_clk and ps2_data; minimum 2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- ps2_clk  input  1  raw PS/2 clock from keyboard, asynchronous
- ps2_data  input  1  raw PS/2 data from keyboard, asynchronous
- key_val  output  3  decoded key: 000-011 = keys 1-4; 100 = up; 101 = down; 110 = left; 111 = right
- press  output  1  1 = make (key down), 0 = break (key released)
- ready  output  1  one-cycle strobe; key_val/press updated this cycle
- frame_err  output  1  one-cycle strobe on parity, stop-bit or timeout error

Behaviour:
- Reset (async, rst=1): key_val=3'b000, press=1, ready=0, frame_err=0. Receiver returns to IDLE; E0/F0 flags, bit counter and timeout counter clear. Reset mid-frame discards the partial frame. rst dominates every other event.
- Input sync: ps2_clk and ps2_data each pass through SYNC_STAGES flops. A falling edge is detected when synced ps2_clk is 1 in the previous cycle and 0 now; synced ps2_data is sampled in that cycle.
- Receiver FSM, one transition per falling edge:
  - IDLE: sampled 0 -> DATA (bit count 0). Sampled 1 is treated as a glitch: stay IDLE, no error.
  - DATA: shift bits in LSB first; after the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: sampled 1 with odd parity over the 8 data bits plus parity bit -> byte_valid pulses next cycle. Otherwise frame_err pulses next cycle and the E0/F0 flags clear. Either way -> IDLE.
- Timeout: the counter resets on every falling edge and runs only when not IDLE. Reaching TIMEOUT_CYCLES-1 -> IDLE, frame_err pulses, E0/F0 flags clear.
- Decoder, acting on byte_valid:
  - 0xE0: set ext.
  - 0xF0: set brk.
  - Any other byte: look up {ext, byte} and clear ext and brk regardless of the lookup result.
- Lookup table:
  - ext=0: 0x16 -> 000; 0x1E -> 001; 0x26 -> 010; 0x25 -> 011.
  - ext=1: 0x75 -> 100; 0x72 -> 101; 0x6B -> 110; 0x74 -> 111.
  - A code only matches with the listed ext value; for example, ext=1 with 0x16 does not match.
- On a match, in the cycle after byte_valid: key_val = code, press = ~brk, ready = 1 for exactly one cycle.
- Unmapped codes: no ready pulse; outputs unchanged.
- key_val and press hold their values between ready pulses.
- Latency: ready asserts 2 clk cycles after the cycle in which the stop bit is sampled.
- Prefix order: both E0 F0 xx and F0 E0 xx are accepted as extended breaks.
- Repeated prefixes are idempotent.
- A new frame may begin immediately after STOP; no gap is required.

Optional Feature:
- KEY_REPEAT_FILTER_EN defined:
  - An 8-bit held mask (one bit per key_val) is kept.
  - A make for a key whose mask bit is already set produces no ready pulse, which suppresses typematic auto-repeat.
  - A make for a key not held sets its bit and emits ready; a break clears its bit and always emits ready.
  - The mask clears on rst.
- Undefined: every mapped make emits ready, including auto-repeats.

Test Plan:
- Frame 0x1E then F0 1E, correct parity -> ready pulses with key_val=001, press=1, then key_val=001, press=0; exactly 2 ready pulses.
- E0 6B, then E0 F0 6B -> key_val=110, press=1, then key_val=110, press=0; no ready on the prefix bytes.
- Frame 0x16 with parity bit inverted -> frame_err for 1 cycle, no ready. The next valid 0x16 -> ready with key_val=000, press=1.
- Start bit plus 4 data bits, then ps2_clk held high for TIMEOUT_CYCLES -> frame_err pulse, FSM back in IDLE. A following full 0x25 frame -> ready with key_val=011.
- Unmapped 0x1C, then rst asserted mid-frame during a 0x75 frame -> no ready from 0x1C; outputs at reset values (000, press=1). A post-reset E0 75 -> key_val=100, press=1.
- With KEY_REPEAT_FILTER_EN: E0 74 sent 3 times, then E0 F0 74 -> exactly 2 ready pulses (make with press=1, break with press=0). Without the macro: 4 ready pulses.
